// File: rtl/oven_pkg.sv
// oven_pkg: shared widths, default constants and state encoding for the oven controller
package oven_pkg;
  localparam int TIME_W = 13;
  localparam int TEMP_W = 10;
  localparam int CLOCK_MAX = 5999;
  localparam int D_CLK_HZ = 50_000_000;
  localparam int D_TEMP_MIN = 100;
  localparam int D_TEMP_MAX = 550;
  localparam int D_TEMP_STEP = 5;
  localparam int D_TIME_STEP = 10;
  localparam int D_TIME_MAX = 5999;
  localparam int D_AMBIENT = 70;
  localparam int D_RAMP = 5;
  localparam int D_COOL = 1;
  localparam int D_DEF_TEMP = 350;
  localparam int D_DEF_TIME = 600;
  typedef enum logic [2:0] {OFF, SET_TEMP, SET_TIME, PREHEAT, COOK, DONE} state_t;
endpackage

// File: rtl/oven_tick_gen.sv
// oven_tick_gen: prescaler giving a 1-cycle tick every CLK_HZ clocks
module oven_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_HZ - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/oven_controller.sv
// oven_controller: input sync, oven state machine, thermal model, kitchen clock and cook countdown
module oven_controller
  import oven_pkg::*;
#(
  parameter int CLK_HZ = D_CLK_HZ,
  parameter int TEMP_MIN = D_TEMP_MIN,
  parameter int TEMP_MAX = D_TEMP_MAX,
  parameter int TEMP_STEP = D_TEMP_STEP,
  parameter int TIME_STEP = D_TIME_STEP,
  parameter int TIME_MAX = D_TIME_MAX,
  parameter int AMBIENT = D_AMBIENT,
  parameter int RAMP = D_RAMP,
  parameter int COOL = D_COOL,
  parameter int DEF_TEMP = D_DEF_TEMP,
  parameter int DEF_TIME = D_DEF_TIME
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power_sw,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_enter,
  output logic              power,
  output logic              tempInputDone,
  output logic              timeInputDone,
  output logic [TEMP_W-1:0] current_temp,
  output logic [TEMP_W-1:0] target_temp,
  output logic [TIME_W-1:0] current_time,
  output logic [TIME_W-1:0] target_time,
  output logic [TIME_W-1:0] remaining_time,
  output logic              heater_on,
  output logic              done_alarm
);
  logic [1:0] pwr_q, up_q, dn_q, en_q;
  logic up_d, dn_d, en_d, tick, pwr, up, dn, en, heating;
  logic [TEMP_W:0] heat_w, tt_up_w;
  logic [TIME_W:0] tm_up_w;
  logic [TEMP_W-1:0] hot, cold, temp_n, tt_up, tt_dn, tgt_temp_n;
  logic [TIME_W-1:0] tm_up, tm_dn, tgt_time_n, rem_n;
  state_t state, state_n;

  oven_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {pwr_q, up_q, dn_q, en_q} <= '0;
      {up_d, dn_d, en_d} <= '0;
    end else begin
      pwr_q <= {pwr_q[0], power_sw};
      up_q <= {up_q[0], btn_up};
      dn_q <= {dn_q[0], btn_down};
      en_q <= {en_q[0], btn_enter};
      {up_d, dn_d, en_d} <= {up_q[1], dn_q[1], en_q[1]};
    end

  // simultaneous up+down presses cancel each other
  assign pwr = pwr_q[1];
  assign up = up_q[1] & ~up_d & ~(dn_q[1] & ~dn_d);
  assign dn = dn_q[1] & ~dn_d & ~(up_q[1] & ~up_d);
  assign en = en_q[1] & ~en_d;

  // all arithmetic one bit wider, then clamped
  assign heat_w = {1'b0, current_temp} + (TEMP_W+1)'(RAMP);
  assign hot = heat_w > {1'b0, target_temp} ? target_temp : heat_w[TEMP_W-1:0];
  assign cold = current_temp >= TEMP_W'(AMBIENT + COOL) ? current_temp - TEMP_W'(COOL) : TEMP_W'(AMBIENT);
  assign heating = state == PREHEAT || (state == COOK && current_temp < target_temp);
  assign temp_n = !tick ? current_temp : heating ? hot : cold;
  assign tt_up_w = {1'b0, target_temp} + (TEMP_W+1)'(TEMP_STEP);
  assign tt_up = tt_up_w > (TEMP_W+1)'(TEMP_MAX) ? TEMP_W'(TEMP_MAX) : tt_up_w[TEMP_W-1:0];
  assign tt_dn = target_temp < TEMP_W'(TEMP_MIN + TEMP_STEP) ? TEMP_W'(TEMP_MIN) : target_temp - TEMP_W'(TEMP_STEP);
  assign tm_up_w = {1'b0, target_time} + (TIME_W+1)'(TIME_STEP);
  assign tm_up = tm_up_w > (TIME_W+1)'(TIME_MAX) ? TIME_W'(TIME_MAX) : tm_up_w[TIME_W-1:0];
  assign tm_dn = target_time < TIME_W'(TIME_STEP) ? '0 : target_time - TIME_W'(TIME_STEP);

  always_comb begin
    state_n = state;
    tgt_temp_n = target_temp;
    tgt_time_n = target_time;
    rem_n = remaining_time;
    if (!pwr) begin
      state_n = OFF;
      rem_n = '0;
    end else
      case (state)
        OFF: state_n = SET_TEMP;
        SET_TEMP: begin
          tgt_temp_n = up ? tt_up : dn ? tt_dn : target_temp;
          state_n = en ? SET_TIME : SET_TEMP;
        end
        SET_TIME: begin
          tgt_time_n = up ? tm_up : dn ? tm_dn : target_time;
          if (en && target_time != '0) begin
            state_n = PREHEAT;
            rem_n = target_time;
          end
        end
        PREHEAT: state_n = current_temp >= target_temp ? COOK : PREHEAT;
        COOK: if (tick) begin
          rem_n = remaining_time - TIME_W'(1);
          state_n = remaining_time == TIME_W'(1) ? DONE : COOK;
        end
        DONE: state_n = en ? SET_TEMP : DONE;
        default: state_n = OFF;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= OFF;
      {power, tempInputDone, timeInputDone, heater_on, done_alarm} <= '0;
      current_temp <= TEMP_W'(AMBIENT);
      target_temp <= TEMP_W'(DEF_TEMP);
      current_time <= '0;
      target_time <= TIME_W'(DEF_TIME);
      remaining_time <= '0;
    end else begin
      state <= state_n;
      power <= state_n != OFF;
      tempInputDone <= !(state_n inside {OFF, SET_TEMP});
      timeInputDone <= state_n inside {PREHEAT, COOK, DONE};
      heater_on <= state_n == PREHEAT || (state_n == COOK && temp_n < tgt_temp_n);
      done_alarm <= state_n == DONE;
      current_temp <= temp_n;
      target_temp <= tgt_temp_n;
      target_time <= tgt_time_n;
      remaining_time <= rem_n;
      if (tick) current_time <= current_time == TIME_W'(CLOCK_MAX) ? '0 : current_time + TIME_W'(1);
    end
endmodule

// File: tb/tb_oven_controller.sv
// tb_oven_controller: vector table with scoreboard plus multi-cycle sequences for the oven controller
module tb_oven_controller;
  typedef struct packed {
    logic p, ti, tm, heat, alarm;
    logic [9:0] ctemp, ttemp;
    logic [12:0] ttime, rem;
  } snap_t;
  typedef struct {
    logic pw, up, dn, en;
    snap_t exp;
  } vec_t;

  logic clk = 0, rst_n = 0, power_sw = 0, btn_up = 0, btn_down = 0, btn_enter = 0;
  logic power, tempInputDone, timeInputDone, heater_on, done_alarm;
  logic [9:0] current_temp, target_temp;
  logic [12:0] current_time, target_time, remaining_time;
  int n_vec = 0, n_err = 0;
  snap_t sb[$];
  vec_t tbl[13];

  oven_controller #(.CLK_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .power_sw(power_sw), .btn_up(btn_up), .btn_down(btn_down),
    .btn_enter(btn_enter), .power(power), .tempInputDone(tempInputDone),
    .timeInputDone(timeInputDone), .current_temp(current_temp), .target_temp(target_temp),
    .current_time(current_time), .target_time(target_time), .remaining_time(remaining_time),
    .heater_on(heater_on), .done_alarm(done_alarm)
  );

  always #5 clk = ~clk;

  function automatic snap_t cur();
    return {power, tempInputDone, timeInputDone, heater_on, done_alarm, current_temp,
            target_temp, target_time, remaining_time};
  endfunction

  function automatic vec_t mk(logic pw, logic u, logic d, logic e, logic p, logic ti, logic tm,
                              logic [9:0] tt, logic [12:0] tim);
    vec_t v;
    v.pw = pw; v.up = u; v.dn = d; v.en = e;
    v.exp = {p, ti, tm, 1'b0, 1'b0, 10'd70, tt, tim, 13'd0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, required event never seen", nm);
  endtask

  task automatic press(input logic u, input logic d, input logic e);
    {btn_up, btn_down, btn_enter} = {u, d, e};
    @(negedge clk);
    {btn_up, btn_down, btn_enter} = 3'b000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int prev, n;
    bit done;
    snap_t e;
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 350, 600);
    tbl[1]  = mk(1, 1, 0, 0, 1, 0, 0, 355, 600);
    tbl[2]  = mk(1, 1, 0, 0, 1, 0, 0, 360, 600);
    tbl[3]  = mk(1, 0, 1, 0, 1, 0, 0, 355, 600);
    tbl[4]  = mk(1, 1, 1, 0, 1, 0, 0, 355, 600);
    tbl[5]  = mk(1, 1, 0, 0, 1, 0, 0, 360, 600);
    tbl[6]  = mk(1, 0, 0, 1, 1, 1, 0, 360, 600);
    tbl[7]  = mk(1, 1, 0, 0, 1, 1, 0, 360, 610);
    tbl[8]  = mk(1, 0, 1, 0, 1, 1, 0, 360, 600);
    tbl[9]  = mk(1, 1, 1, 0, 1, 1, 0, 360, 600);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 360, 600);
    tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 360, 600);
    tbl[12] = mk(1, 0, 0, 1, 1, 1, 0, 360, 600);

    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", cur(), {5'b0, 10'd70, 10'd350, 13'd600, 13'd0});
    chk("idle_clock", current_time, 10);

    foreach (tbl[i]) begin
      power_sw = tbl[i].pw;
      {btn_up, btn_down, btn_enter} = {tbl[i].up, tbl[i].dn, tbl[i].en};
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      {btn_up, btn_down, btn_enter} = 3'b000;
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), cur(), e);
    end

    repeat (65) press(0, 1, 0);
    settle();
    chk("time_floor", target_time, 0);
    press(0, 0, 1);
    settle();
    chk("enter_zero_timedone", timeInputDone, 0);
    chk("enter_zero_tempdone", tempInputDone, 1);
    press(1, 0, 0);
    settle();
    chk("still_set_time", target_time, 10);
    press(0, 1, 0);

    power_sw = 0;
    settle();
    power_sw = 1;
    settle();
    repeat (40) press(1, 0, 0);
    settle();
    chk("temp_ceiling", target_temp, 550);
    press(1, 0, 0);
    settle();
    chk("temp_ceiling_hold", target_temp, 550);
    repeat (100) press(0, 1, 0);
    settle();
    chk("temp_floor", target_temp, 100);
    press(0, 0, 1);
    repeat (2) press(1, 0, 0);
    settle();
    chk("time_set", target_time, 20);
    chk("temp_start", current_temp, 70);

    press(0, 0, 1);
    prev = current_temp; n = 0; done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (int'(current_temp) != prev) begin
        chk("preheat_step", current_temp, prev + 5 > 100 ? 100 : prev + 5);
        chk("preheat_heater", heater_on, 1);
        prev = current_temp;
        n++;
      end
      if (current_temp == 100) done = 1;
    end
    if (!done) tmo("preheat");
    chk("preheat_ticks", n, 6);
    @(negedge clk);
    chk("cook_heater_at_target", heater_on, 0);
    chk("cook_remaining", remaining_time, 20);
    chk("cook_timedone", timeInputDone, 1);

    prev = remaining_time; n = 0; done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (int'(remaining_time) != prev) begin
        chk("countdown_step", remaining_time, prev - 1);
        prev = remaining_time;
        n++;
      end
      if (remaining_time == 0) done = 1;
    end
    if (!done) tmo("countdown");
    chk("countdown_ticks", n, 20);
    chk("done_alarm", done_alarm, 1);
    chk("done_heater", heater_on, 0);
    chk("done_temp", current_temp, 100);

    press(0, 0, 1);
    settle();
    chk("reenter_flags", {done_alarm, tempInputDone, timeInputDone}, 0);
    chk("targets_kept", {target_temp, target_time}, {10'd100, 13'd20});

    press(0, 0, 1);
    press(0, 0, 1);
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (remaining_time == 19) done = 1;
    end
    if (!done) tmo("second_cook");
    power_sw = 0;
    repeat (3) @(negedge clk);
    chk("off_power", power, 0);
    chk("off_heater", heater_on, 0);
    chk("off_remaining", remaining_time, 0);
    prev = current_temp; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (int'(current_temp) != prev) begin
        chk("cool_step", current_temp, prev - 1);
        prev = current_temp;
      end
      if (current_temp == 70) done = 1;
    end
    if (!done) tmo("cooldown");
    repeat (30) @(negedge clk);
    chk("cool_floor", current_temp, 70);

    done = 0;
    for (int i = 0; i < 70000 && !done; i++) begin
      @(negedge clk);
      if (current_time == 5999) done = 1;
    end
    if (!done) tmo("clock_5999");
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (current_time != 5999) done = 1;
    end
    if (!done) tmo("clock_wrap");
    chk("clock_wrap", current_time, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
